// File: rtl/jtframe_romarb_pkg.sv
// jtframe_romarb shared types: FSM states, index width and slot offset helpers.
// Offsets are carried in a fixed-width container so one helper serves any SLOTS/SDRAM_AW.
package jtframe_romarb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } st_t;

  localparam int MAX_SLOTS = 8;
  localparam int MAX_AW    = 32;
  localparam int OFF_W     = MAX_SLOTS * MAX_AW;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [MAX_AW-1:0] slot_offset(
    input logic [OFF_W-1:0] offs,
    input int               aw,
    input int               s
  );
    logic [OFF_W-1:0]  sh;
    logic [MAX_AW-1:0] m;
    sh = offs >> (s * aw);
    m  = {MAX_AW{1'b1}} >> (MAX_AW - aw);
    return sh[MAX_AW-1:0] & m;
  endfunction

endpackage

// File: rtl/jtframe_romarb_pick.sv
// jtframe_romarb_pick: combinational fixed / round-robin slot picker.
// In: pend (SLOTS), ptr (IW). Out: valid, idx (IW).
module jtframe_romarb_pick #(
  parameter int SLOTS = 4,
  parameter bit RR    = 1'b0,
  parameter int IW    = 2
)(
  input  logic [SLOTS-1:0] pend,
  input  logic [IW-1:0]    ptr,
  output logic             valid,
  output logic [IW-1:0]    idx
);

  logic [IW-1:0] lo;
  logic [IW-1:0] hi;
  logic          hi_v;

  // lo: lowest pending overall; hi: lowest pending at/after ptr.
  // Round-robin wraps to lo when nothing sits at/after ptr.
  always_comb begin
    lo   = '0;
    hi   = '0;
    hi_v = 1'b0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (pend[i]) lo = IW'(i);
      if (pend[i] && (!RR || IW'(i) >= ptr)) begin
        hi   = IW'(i);
        hi_v = 1'b1;
      end
    end
    valid = |pend;
    idx   = hi_v ? hi : lo;
  end

endmodule

// File: rtl/jtframe_romarb.sv
// jtframe_romarb: N-slot SDRAM read arbiter with a one-entry cache per slot.
// Ports: slot_cs/addr in, slot_ok/dout out; sdram_req/addr out, ack/dst/rdy/read in.
module jtframe_romarb
  import jtframe_romarb_pkg::*;
#(
  parameter int                        SLOTS    = 4,
  parameter int                        AW       = 17,
  parameter int                        SDRAM_AW = 22,
  parameter logic [SLOTS*SDRAM_AW-1:0] OFFSETS  = '0,
  parameter bit                        RR       = 1'b0
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  downloading,
  input  logic [SLOTS-1:0]      slot_cs,
  input  logic [SLOTS*AW-1:0]   slot_addr,
  output logic [SLOTS-1:0]      slot_ok,
  output logic [SLOTS*32-1:0]   slot_dout,
  output logic                  sdram_req,
  output logic [SDRAM_AW-1:0]   sdram_addr,
  input  logic                  sdram_ack,
  input  logic                  data_dst,
  input  logic                  data_rdy,
  input  logic [15:0]           data_read
);

  localparam int IW = idx_w(SLOTS);

  st_t st, st_nx;

  logic [AW-1:0]       saddr [SLOTS];
  logic [SDRAM_AW-1:0] faddr [SLOTS];
  logic [AW-1:0]       tag   [SLOTS];
  logic [31:0]         data  [SLOTS];
  logic [SLOTS-1:0]    valid;
  logic [SLOTS-1:0]    hit;
  logic [SLOTS-1:0]    pend;

  logic          pick_v;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] ptr;
  logic [IW-1:0] win;
  logic [AW-1:0] tag_l;
  logic [31:0]   fill;
  logic [31:0]   fill_nx;
  logic          drop;
  logic          go;
  logic          commit;

  for (genvar s = 0; s < SLOTS; s++) begin : g_slot
    localparam logic [SDRAM_AW-1:0] OFF =
      SDRAM_AW'(slot_offset(OFF_W'(OFFSETS), SDRAM_AW, s));
    assign saddr[s] = slot_addr[s*AW +: AW];
    assign hit[s]   = slot_cs[s] & valid[s] & (tag[s] == saddr[s]);
    assign faddr[s] = OFF + SDRAM_AW'({saddr[s], 1'b0});
    assign slot_dout[s*32 +: 32] = data[s];
  end

  assign pend = slot_cs & ~hit;

  jtframe_romarb_pick #(
    .SLOTS (SLOTS),
    .RR    (RR),
    .IW    (IW)
  ) u_pick (
    .pend  (pend),
    .ptr   (ptr),
    .valid (pick_v),
    .idx   (pick_idx)
  );

  assign go      = (st == IDLE) & ~downloading & pick_v;
  // drop: a download touched this fetch, so its data must not be cached
  assign commit  = (st == WAIT) & data_rdy & ~drop & ~downloading;
  assign fill_nx = data_dst ? {data_read, fill[31:16]} : fill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE:    if (go)        st_nx = REQ;
      REQ:     if (sdram_ack) st_nx = WAIT;
      WAIT:    if (data_rdy)  st_nx = IDLE;
      default:                st_nx = IDLE;
    endcase
  end

  always_comb begin
    sdram_req = (st == REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win        <= '0;
      tag_l      <= '0;
      sdram_addr <= '0;
      fill       <= '0;
      drop       <= 1'b0;
      ptr        <= '0;
    end else begin
      if (go) begin
        win        <= pick_idx;
        tag_l      <= saddr[pick_idx];
        sdram_addr <= faddr[pick_idx];
        drop       <= 1'b0;
        if (RR && SLOTS > 1)
          ptr <= (pick_idx == IW'(SLOTS - 1)) ? '0 : pick_idx + 1'b1;
      end
      if (st != IDLE && downloading) drop <= 1'b1;
      if (st == WAIT && data_dst) fill <= fill_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid   <= '0;
      slot_ok <= '0;
      for (int s = 0; s < SLOTS; s++) begin
        tag[s]  <= '0;
        data[s] <= '0;
      end
    end else begin
      slot_ok <= downloading ? '0 : hit;
      if (commit) begin
        data[win]  <= fill_nx;
        tag[win]   <= tag_l;
        valid[win] <= 1'b1;
      end
      if (downloading) valid <= '0;
    end
  end

endmodule

// File: tb/tb_jtframe_romarb.sv
// tb_jtframe_romarb: randomized self-checking bench, fixed (u_fix) and RR (u_rr) DUTs.
// Expected grants, addresses and cache contents come from a slot-level model.
module tb_jtframe_romarb;

  localparam logic [87:0] OFFS =
    {22'h3FFFF0, 22'h20000, 22'h10000, 22'h00200};
  localparam logic [21:0] OFF [4] =
    '{22'h00200, 22'h10000, 22'h20000, 22'h3FFFF0};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         dl   [2];
  logic [3:0]   cs   [2];
  logic [67:0]  addr [2];
  logic         ack  [2];
  logic         dst  [2];
  logic         rdy  [2];
  logic [15:0]  rd   [2];
  logic [3:0]   ok   [2];
  logic [127:0] dout [2];
  logic         req  [2];
  logic [21:0]  sa   [2];

  int n_cmp = 0;
  int n_bad = 0;

  bit          m_val [2][4];
  logic [16:0] m_tag [2][4];
  logic [31:0] m_dat [2][4];
  int          m_ptr = 0;

  always #5 clk = ~clk;

  jtframe_romarb #(
    .SLOTS(4), .AW(17), .SDRAM_AW(22), .OFFSETS(OFFS), .RR(1'b0)
  ) u_fix (
    .clk(clk), .rst_n(rst_n), .downloading(dl[0]),
    .slot_cs(cs[0]), .slot_addr(addr[0]),
    .slot_ok(ok[0]), .slot_dout(dout[0]),
    .sdram_req(req[0]), .sdram_addr(sa[0]), .sdram_ack(ack[0]),
    .data_dst(dst[0]), .data_rdy(rdy[0]), .data_read(rd[0])
  );

  jtframe_romarb #(
    .SLOTS(4), .AW(17), .SDRAM_AW(22), .OFFSETS(OFFS), .RR(1'b1)
  ) u_rr (
    .clk(clk), .rst_n(rst_n), .downloading(dl[1]),
    .slot_cs(cs[1]), .slot_addr(addr[1]),
    .slot_ok(ok[1]), .slot_dout(dout[1]),
    .sdram_req(req[1]), .sdram_addr(sa[1]), .sdram_ack(ack[1]),
    .data_dst(dst[1]), .data_rdy(rdy[1]), .data_read(rd[1])
  );

  function automatic logic [21:0] exp_addr(input int s, input logic [16:0] a);
    return 22'(OFF[s] + {5'd0, a, 1'b0});
  endfunction

  function automatic logic [3:0] mpend(input int d);
    logic [3:0] p;
    for (int s = 0; s < 4; s++)
      p[s] = cs[d][s] && !(m_val[d][s] && m_tag[d][s] == addr[d][s*17 +: 17]);
    return p;
  endfunction

  function automatic int mpick(input int d, input logic [3:0] p);
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (d == 1) ? (m_ptr + k) % 4 : k;
      if (p[j]) return j;
    end
    return 0;
  endfunction

  task automatic mfill(input int d, input int w, input logic [16:0] t,
                       input logic [31:0] v);
    m_val[d][w] = 1'b1;
    m_tag[d][w] = t;
    m_dat[d][w] = v;
    if (d == 1) m_ptr = (w + 1) % 4;
  endtask

  task automatic mclear();
    for (int d = 0; d < 2; d++)
      for (int s = 0; s < 4; s++) m_val[d][s] = 1'b0;
    m_ptr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input int d, output bit to, output int n);
    to = 1'b1;
    n  = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      n++;
      if (req[d]) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic burst(input int d, input logic [31:0] w, input bit dlm);
    ack[d] = 1'b1;
    tick();
    ack[d] = 1'b0;
    if (dlm) dl[d] = 1'b1;
    dst[d] = 1'b1;
    rd[d]  = w[15:0];
    tick();
    rd[d]  = w[31:16];
    rdy[d] = 1'b1;
    tick();
    dst[d] = 1'b0;
    rdy[d] = 1'b0;
    rd[d]  = '0;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      dl[d] = 0; cs[d] = 0; addr[d] = '0;
      ack[d] = 0; dst[d] = 0; rdy[d] = 0; rd[d] = '0;
    end
    rst_n = 1'b0;
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (ok[d] !== 4'b0) begin
        n_bad++; $display("FAIL reset_ok[%0d]: got %b want 0", d, ok[d]);
      end
      n_cmp++;
      if (req[d] !== 1'b0) begin
        n_bad++; $display("FAIL reset_req[%0d]: got %b want 0", d, req[d]);
      end
      n_cmp++;
      if (sa[d] !== 22'h0) begin
        n_bad++; $display("FAIL reset_addr[%0d]: got %h want 0", d, sa[d]);
      end
      n_cmp++;
      if (dout[d] !== 128'h0) begin
        n_bad++; $display("FAIL reset_dout[%0d]: got %h want 0", d, dout[d]);
      end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_miss();
    bit to;
    int n;
    cs[0] = 4'b0010;
    addr[0][17 +: 17] = 17'h5;
    wait_req(0, to, n);
    n_cmp++;
    if (to) begin
      n_bad++; $display("FAIL miss_timeout: got no req want req");
    end
    n_cmp++;
    if (sa[0] !== 22'h1000A) begin
      n_bad++; $display("FAIL miss_addr: got %h want %h", sa[0], 22'h1000A);
    end
    burst(0, 32'hCAFEBEEF, 1'b0);
    mfill(0, 1, 17'h5, 32'hCAFEBEEF);
    n_cmp++;
    if (ok[0][1] !== 1'b0) begin
      n_bad++; $display("FAIL miss_ok_early: got %b want 0", ok[0][1]);
    end
    tick();
    n_cmp++;
    if (ok[0][1] !== 1'b1) begin
      n_bad++; $display("FAIL miss_ok: got %b want 1", ok[0][1]);
    end
    n_cmp++;
    if (dout[0][63:32] !== 32'hCAFEBEEF) begin
      n_bad++; $display("FAIL miss_dout: got %h want CAFEBEEF", dout[0][63:32]);
    end
  endtask

  task automatic test_hit();
    cs[0] = 4'b0000;
    tick();
    n_cmp++;
    if (ok[0][1] !== 1'b0) begin
      n_bad++; $display("FAIL hit_ok_drop: got %b want 0", ok[0][1]);
    end
    cs[0] = 4'b0010;
    tick();
    n_cmp++;
    if (ok[0][1] !== 1'b1) begin
      n_bad++; $display("FAIL hit_ok: got %b want 1", ok[0][1]);
    end
    n_cmp++;
    if (req[0] !== 1'b0) begin
      n_bad++; $display("FAIL hit_req: got %b want 0", req[0]);
    end
    tick();
    n_cmp++;
    if (req[0] !== 1'b0 || dout[0][63:32] !== m_dat[0][1]) begin
      n_bad++;
      $display("FAIL hit_hold: got req %b dout %h want 0 %h",
               req[0], dout[0][63:32], m_dat[0][1]);
    end
  endtask

  task automatic test_fixed_priority();
    bit to;
    int n, w, pw;
    logic [3:0] p;
    logic [16:0] t;
    logic [31:0] v;
    cs[0] = 4'b0000;
    tick();
    addr[0][0 +: 17]  = 17'h100 + 17'($urandom_range(0, 255));
    addr[0][34 +: 17] = 17'($urandom_range(17'h200, 17'h1FFFF));
    addr[0][51 +: 17] = 17'h10;
    cs[0] = 4'b1101;
    pw = 0;
    for (int i = 0; i < 3; i++) begin
      p = mpend(0);
      w = mpick(0, p);
      t = addr[0][w*17 +: 17];
      wait_req(0, to, n);
      n_cmp++;
      if (to) begin
        n_bad++; $display("FAIL fix_timeout: got no req want slot %0d", w);
      end
      if (i > 0) begin
        n_cmp++;
        if (ok[0][pw] !== 1'b1 || n != 1) begin
          n_bad++;
          $display("FAIL fix_b2b: got ok %b after %0d cyc want 1 after 1",
                   ok[0][pw], n);
        end
      end
      n_cmp++;
      if (sa[0] !== exp_addr(w, t)) begin
        n_bad++;
        $display("FAIL fix_grant%0d: got %h want %h (slot %0d)",
                 i, sa[0], exp_addr(w, t), w);
      end
      v = $urandom;
      burst(0, v, 1'b0);
      mfill(0, w, t, v);
      pw = w;
    end
    tick();
    for (int s = 0; s < 4; s++) begin
      if (cs[0][s]) begin
        n_cmp++;
        if (ok[0][s] !== 1'b1 || dout[0][s*32 +: 32] !== m_dat[0][s]) begin
          n_bad++;
          $display("FAIL fix_fill%0d: got ok %b %h want 1 %h",
                   s, ok[0][s], dout[0][s*32 +: 32], m_dat[0][s]);
        end
      end
    end
    n_cmp++;
    if (req[0] !== 1'b0) begin
      n_bad++; $display("FAIL fix_idle: got req %b want 0", req[0]);
    end
    cs[0] = 4'b0000;
    tick();
  endtask

  task automatic test_round_robin();
    bit to;
    int n, w;
    logic [3:0] p;
    logic [16:0] t;
    logic [31:0] v;
    addr[1][17 +: 17] = 17'($urandom_range(0, 17'h1FFFF));
    addr[1][51 +: 17] = 17'($urandom_range(0, 17'h1FFFF));
    cs[1] = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      p = mpend(1);
      w = mpick(1, p);
      t = addr[1][w*17 +: 17];
      wait_req(1, to, n);
      n_cmp++;
      if (to) begin
        n_bad++; $display("FAIL rr_timeout: got no req want slot %0d", w);
      end
      n_cmp++;
      if (sa[1] !== exp_addr(w, t)) begin
        n_bad++;
        $display("FAIL rr_grant%0d: got %h want %h (slot %0d)",
                 i, sa[1], exp_addr(w, t), w);
      end
      v = $urandom;
      burst(1, v, 1'b0);
      mfill(1, w, t, v);
      addr[1][w*17 +: 17] = t ^ 17'(1 + $urandom_range(0, 1000));
    end
    cs[1] = 4'b0000;
    tick();
    n_cmp++;
    if (req[1] !== 1'b0) begin
      n_bad++; $display("FAIL rr_idle: got req %b want 0", req[1]);
    end
  endtask

  task automatic test_download();
    bit to;
    int n;
    logic [16:0] t;
    logic [31:0] v;
    t = m_tag[0][2] ^ 17'(1 + $urandom_range(0, 1000));
    addr[0][34 +: 17] = t;
    cs[0] = 4'b0110;
    wait_req(0, to, n);
    n_cmp++;
    if (to || sa[0] !== exp_addr(2, t)) begin
      n_bad++;
      $display("FAIL dl_req: got req %b addr %h want 1 %h",
               req[0], sa[0], exp_addr(2, t));
    end
    burst(0, $urandom, 1'b1);
    for (int s = 0; s < 4; s++) m_val[0][s] = 1'b0;
    tick();
    n_cmp++;
    if (ok[0] !== 4'b0000) begin
      n_bad++; $display("FAIL dl_ok: got %b want 0000", ok[0]);
    end
    n_cmp++;
    if (req[0] !== 1'b0) begin
      n_bad++; $display("FAIL dl_block: got req %b want 0", req[0]);
    end
    cs[0] = 4'b0100;
    dl[0] = 1'b0;
    wait_req(0, to, n);
    n_cmp++;
    if (to || sa[0] !== exp_addr(2, t)) begin
      n_bad++;
      $display("FAIL dl_refetch: got req %b addr %h want 1 %h",
               req[0], sa[0], exp_addr(2, t));
    end
    v = $urandom;
    burst(0, v, 1'b0);
    mfill(0, 2, t, v);
    tick();
    n_cmp++;
    if (ok[0][2] !== 1'b1 || dout[0][95:64] !== v) begin
      n_bad++;
      $display("FAIL dl_fill: got ok %b %h want 1 %h", ok[0][2], dout[0][95:64], v);
    end
    cs[0] = 4'b0110;
    wait_req(0, to, n);
    n_cmp++;
    if (to || sa[0] !== 22'h1000A) begin
      n_bad++;
      $display("FAIL dl_flushed: got req %b addr %h want 1 1000A", req[0], sa[0]);
    end
    burst(0, $urandom, 1'b0);
    cs[0] = 4'b0000;
    tick();
  endtask

  task automatic test_addr_change();
    bit to;
    int n;
    logic [31:0] v1, v2;
    v1 = $urandom;
    v2 = $urandom;
    addr[0][0 +: 17] = 17'h4;
    cs[0] = 4'b0001;
    wait_req(0, to, n);
    n_cmp++;
    if (to || sa[0] !== 22'h208) begin
      n_bad++; $display("FAIL ac_req: got req %b addr %h want 1 208", req[0], sa[0]);
    end
    ack[0] = 1'b1;
    tick();
    ack[0] = 1'b0;
    addr[0][0 +: 17] = 17'h9;
    dst[0] = 1'b1; rd[0] = v1[15:0];
    tick();
    rd[0] = v1[31:16]; rdy[0] = 1'b1;
    tick();
    dst[0] = 1'b0; rdy[0] = 1'b0; rd[0] = '0;
    tick();
    n_cmp++;
    if (ok[0][0] !== 1'b0) begin
      n_bad++; $display("FAIL ac_ok: got %b want 0", ok[0][0]);
    end
    n_cmp++;
    if (req[0] !== 1'b1 || sa[0] !== 22'h212) begin
      n_bad++; $display("FAIL ac_req2: got req %b addr %h want 1 212", req[0], sa[0]);
    end
    addr[0][0 +: 17] = 17'h4;
    tick();
    n_cmp++;
    if (ok[0][0] !== 1'b1 || dout[0][31:0] !== v1) begin
      n_bad++;
      $display("FAIL ac_tag4: got ok %b %h want 1 %h", ok[0][0], dout[0][31:0], v1);
    end
    burst(0, v2, 1'b0);
    tick();
    n_cmp++;
    if (ok[0][0] !== 1'b0 || req[0] !== 1'b1 || sa[0] !== 22'h208) begin
      n_bad++;
      $display("FAIL ac_tag9: got ok %b req %b addr %h want 0 1 208",
               ok[0][0], req[0], sa[0]);
    end
    addr[0][0 +: 17] = 17'h9;
    tick();
    n_cmp++;
    if (ok[0][0] !== 1'b1 || dout[0][31:0] !== v2) begin
      n_bad++;
      $display("FAIL ac_hit9: got ok %b %h want 1 %h", ok[0][0], dout[0][31:0], v2);
    end
    burst(0, $urandom, 1'b0);
    cs[0] = 4'b0000;
    tick();
  endtask

  task automatic test_reset_midburst();
    bit to;
    int n;
    logic [16:0] t;
    logic [31:0] v;
    t = 17'($urandom_range(0, 17'h1FFFF));
    addr[1][0 +: 17] = t;
    cs[1] = 4'b0001;
    wait_req(1, to, n);
    n_cmp++;
    if (to || sa[1] !== exp_addr(0, t)) begin
      n_bad++;
      $display("FAIL rst_req: got req %b addr %h want 1 %h", req[1], sa[1], exp_addr(0, t));
    end
    ack[1] = 1'b1;
    tick();
    ack[1] = 1'b0;
    dst[1] = 1'b1; rd[1] = 16'h1234;
    tick();
    rst_n = 1'b0;
    #1;
    mclear();
    n_cmp++;
    if (req[1] !== 1'b0 || sa[1] !== 22'h0) begin
      n_bad++; $display("FAIL rst_async: got req %b addr %h want 0 0", req[1], sa[1]);
    end
    n_cmp++;
    if (dout[0] !== 128'h0 || ok[0] !== 4'b0) begin
      n_bad++; $display("FAIL rst_cache: got ok %b dout %h want 0 0", ok[0], dout[0]);
    end
    cs[1] = 4'b0000;
    dst[1] = 1'b0;
    tick();
    rst_n = 1'b1;
    dst[1] = 1'b1; rdy[1] = 1'b1; rd[1] = 16'h5678;
    tick();
    dst[1] = 1'b0; rdy[1] = 1'b0; rd[1] = '0;
    tick();
    n_cmp++;
    if (req[1] !== 1'b0 || ok[1] !== 4'b0 || dout[1] !== 128'h0) begin
      n_bad++;
      $display("FAIL rst_stray: got req %b ok %b dout %h want 0 0 0",
               req[1], ok[1], dout[1]);
    end
    cs[1] = 4'b0001;
    wait_req(1, to, n);
    n_cmp++;
    if (to || sa[1] !== exp_addr(0, t)) begin
      n_bad++;
      $display("FAIL rst_refetch: got req %b addr %h want 1 %h",
               req[1], sa[1], exp_addr(0, t));
    end
    v = $urandom;
    burst(1, v, 1'b0);
    mfill(1, 0, t, v);
    tick();
    n_cmp++;
    if (ok[1][0] !== 1'b1 || dout[1][31:0] !== m_dat[1][0]) begin
      n_bad++;
      $display("FAIL rst_fill: got ok %b %h want 1 %h", ok[1][0], dout[1][31:0], m_dat[1][0]);
    end
    cs[1] = 4'b0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_miss();
    test_hit();
    test_fixed_priority();
    test_round_robin();
    test_download();
    test_addr_change();
    test_reset_midburst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
